// File: rtl/tree_walk_ctrl.sv
// Decision-tree walk sequencer: latches a feature vector, walks the node SRAM
// from the root to a leaf, and passes host table writes through when idle.
module tree_walk_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int NODE_WIDTH = 36,
  parameter int NUM_FEAT   = 5,
  parameter int ROOT_ADDR  = 0,
  parameter int MAX_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*NUM_FEAT-1:0]   feat_in,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              class_out,
  output logic                    error,
  input  logic                    host_wr,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  input  logic [NODE_WIDTH-1:0]   host_wdata,
  output logic                    host_ack,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  output logic                    mem_we,
  output logic [NODE_WIDTH-1:0]   mem_wdata,
  input  logic [NODE_WIDTH-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  typedef struct packed {
    logic [11:0] right;
    logic [11:0] left;
    logic [2:0]  fsel;
    logic        rsvd;
    logic [7:0]  thr;
  } node_t;

  state_t                       state, state_d;
  logic [NUM_FEAT-1:0][7:0]     feat_q, feat_d;
  logic [ADDR_WIDTH-1:0]        node_addr, addr_d;
  logic [7:0]                   depth, depth_d;
  logic [7:0]                   class_d;
  logic                         err_d;

  node_t       node;
  logic [7:0]  feat_sel;
  logic        sel_bad;
  logic [11:0] ptr;
  logic        unused_bits;

  assign node        = node_t'(mem_rdata);
  assign sel_bad     = int'(node.fsel) >= NUM_FEAT;
  assign ptr         = (feat_sel < node.thr) ? node.left : node.right;
  assign unused_bits = ^{node.rsvd, ptr};

  always_comb begin
    feat_sel = '0;
    for (int i = 0; i < NUM_FEAT; i++)
      if (node.fsel == 3'(i)) feat_sel = feat_q[i];
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      feat_q    <= '0;
      node_addr <= '0;
      depth     <= '0;
      class_out <= '0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      feat_q    <= feat_d;
      node_addr <= addr_d;
      depth     <= depth_d;
      class_out <= class_d;
      error     <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    feat_d    = feat_q;
    addr_d    = node_addr;
    depth_d   = depth;
    class_d   = class_out;
    err_d     = error;
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    host_ack  = 1'b0;
    case (state)
      IDLE: begin
        // host write has priority; start is taken on a later idle cycle
        if (host_wr) begin
          mem_we    = 1'b1;
          mem_addr  = host_addr;
          mem_wdata = host_wdata;
          host_ack  = 1'b1;
        end else if (start) begin
          feat_d  = feat_in;
          addr_d  = ADDR_WIDTH'(ROOT_ADDR);
          depth_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = node_addr;
        depth_d  = depth + 8'd1;
        state_d  = EVAL;
      end
      EVAL: begin
        state_d = DONE;
        if (sel_bad) begin
          class_d = '0;
          err_d   = 1'b1;
        end else if (ptr[11]) begin
          class_d = ptr[7:0];
          err_d   = 1'b0;
        end else if (depth == 8'(MAX_DEPTH)) begin
          class_d = '0;
          err_d   = 1'b1;
        end else begin
          // upper pointer bits are dropped, so addresses wrap
          addr_d  = ptr[ADDR_WIDTH-1:0];
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Directed bench for tree_walk_ctrl with a behavioural single-port node SRAM.
module tb_tree_walk_ctrl;
  localparam int AW = 6;
  localparam int NW = 36;

  logic          clk = 1'b0;
  logic          rst, start, host_wr;
  logic [39:0]   feat_in;
  logic          busy, done, error, host_ack, mem_rd, mem_we;
  logic [7:0]    class_out;
  logic [AW-1:0] host_addr, mem_addr;
  logic [NW-1:0] host_wdata, mem_wdata, mem_rdata;

  logic [NW-1:0] sram [0:63];
  logic [AW-1:0] rd_addr [0:7];
  int checks = 0;
  int failures = 0;

  tree_walk_ctrl #(.ADDR_WIDTH(AW), .NODE_WIDTH(NW), .NUM_FEAT(5),
                   .ROOT_ADDR(0), .MAX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .feat_in(feat_in),
    .busy(busy), .done(done), .class_out(class_out), .error(error),
    .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= sram[mem_addr];
  end

  function automatic logic [35:0] mk(input logic [11:0] r, input logic [11:0] l,
                                     input logic [2:0] s, input logic [7:0] t);
    return {r, l, s, 1'b0, t};
  endfunction

  function automatic logic [11:0] lf(input logic [7:0] c);
    return {4'h8, c};
  endfunction

  // Called just after a negedge in IDLE; returns just after a negedge in IDLE.
  task automatic host_write(input logic [AW-1:0] a, input logic [NW-1:0] d);
    int waited = 0;
    host_wr = 1'b1; host_addr = a; host_wdata = d;
    #1;
    while (!host_ack && waited < 100) begin
      @(negedge clk); #1; waited++;
    end
    checks++;
    if (!host_ack) begin
      failures++; $display("FAIL host_write_ack addr=%0d got ack=%b want 1", a, host_ack);
    end
    @(negedge clk);
    host_wr = 1'b0;
  endtask

  task automatic run_walk(input logic [39:0] f, output int cyc, output logic [7:0] cls,
                          output logic er, output int rds);
    feat_in = f; start = 1'b1;
    cyc = 0; rds = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++; $display("FAIL walk_busy_after_accept got %b want 1", busy);
        end
        start = 1'b0; feat_in = ~f;
      end
      if (mem_rd) begin
        if (rds < 8) rd_addr[rds] = mem_addr;
        rds++;
      end
    end while (!done && cyc < 200);
    cls = class_out; er = error;
    @(negedge clk);
  endtask

  task automatic load_three();
    host_write(6'd0, mk(12'h004, lf(8'h01), 3'd2, 8'h10));
    host_write(6'd4, mk(lf(8'h02), 12'h049, 3'd4, 8'hF0));
    host_write(6'd9, mk(lf(8'h2A), lf(8'h03), 3'd1, 8'h40));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; host_wr = 1'b0; feat_in = '0;
    host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, host_ack, mem_rd, mem_we} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got %b want 000000",
                           {busy, done, error, host_ack, mem_rd, mem_we});
    end
    checks++;
    if (class_out !== 8'h00 || mem_addr !== '0 || mem_wdata !== '0) begin
      failures++; $display("FAIL reset_data got class=%h addr=%h wdata=%h want 0",
                           class_out, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_node();
    int cyc, rds; logic [7:0] cls; logic er;
    host_write(6'd0, mk(12'h805, 12'h803, 3'd0, 8'h80));
    run_walk(40'h00_0000_007F, cyc, cls, er, rds);
    checks++;
    if (cls !== 8'h03 || er !== 1'b0 || cyc != 3) begin
      failures++; $display("FAIL single_left got class=%h err=%b cyc=%0d want 03 0 3", cls, er, cyc);
    end
    run_walk(40'h00_0000_0080, cyc, cls, er, rds);
    checks++;
    if (cls !== 8'h05 || er !== 1'b0 || cyc != 3) begin
      failures++; $display("FAIL single_right got class=%h err=%b cyc=%0d want 05 0 3", cls, er, cyc);
    end
  endtask

  task automatic test_bad_sel();
    int cyc, rds; logic [7:0] cls; logic er;
    host_write(6'd0, mk(lf(8'h01), lf(8'h02), 3'd7, 8'h80));
    run_walk(40'h0, cyc, cls, er, rds);
    checks++;
    if (cls !== 8'h00 || er !== 1'b1 || cyc != 3) begin
      failures++; $display("FAIL bad_sel got class=%h err=%b cyc=%0d want 00 1 3", cls, er, cyc);
    end
  endtask

  task automatic test_three_level();
    int cyc, rds; logic [7:0] cls; logic er;
    load_three();
    run_walk(40'h00_00_10_40_00, cyc, cls, er, rds);
    checks++;
    if (cls !== 8'h2A || er !== 1'b0 || cyc != 7) begin
      failures++; $display("FAIL three_level got class=%h err=%b cyc=%0d want 2a 0 7", cls, er, cyc);
    end
    checks++;
    if (rds != 3 || rd_addr[0] !== 6'd0 || rd_addr[1] !== 6'd4 || rd_addr[2] !== 6'd9) begin
      failures++; $display("FAIL three_addr_seq got n=%0d %0d,%0d,%0d want 3 0,4,9",
                           rds, rd_addr[0], rd_addr[1], rd_addr[2]);
    end
  endtask

  task automatic test_loop();
    int cyc, rds; logic [7:0] cls; logic er;
    host_write(6'd0, mk(lf(8'h01), 12'h000, 3'd0, 8'h80));
    run_walk(40'h0, cyc, cls, er, rds);
    checks++;
    if (cls !== 8'h00 || er !== 1'b1 || cyc != 9) begin
      failures++; $display("FAIL loop_depth got class=%h err=%b cyc=%0d want 00 1 9", cls, er, cyc);
    end
    checks++;
    if (rds != 4) begin
      failures++; $display("FAIL loop_reads got %0d want 4", rds);
    end
  endtask

  task automatic test_arbitration();
    int cyc, viol;
    host_write(6'd0, mk(12'h805, 12'h803, 3'd0, 8'h80));
    host_wr = 1'b1; host_addr = 6'd20; host_wdata = 36'h1_2345_6789;
    start = 1'b1; feat_in = 40'h7F;
    #1;
    checks++;
    if (host_ack !== 1'b1 || mem_we !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 6'd20) begin
      failures++; $display("FAIL arb_write_first got ack=%b we=%b rd=%b addr=%0d want 1 1 0 20",
                           host_ack, mem_we, mem_rd, mem_addr);
    end
    @(negedge clk);
    host_wr = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL arb_start_deferred got busy=%b want 0", busy);
    end
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) start = 1'b0;
    end while (!done && cyc < 200);
    checks++;
    if (class_out !== 8'h03 || cyc != 3) begin
      failures++; $display("FAIL arb_walk got class=%h cyc=%0d want 03 3", class_out, cyc);
    end
    checks++;
    if (sram[20] !== 36'h1_2345_6789) begin
      failures++; $display("FAIL arb_write_data got %h want 123456789", sram[20]);
    end
    @(negedge clk);
    host_write(6'd0, mk(lf(8'h01), 12'h000, 3'd0, 8'h80));
    start = 1'b1; feat_in = 40'h0; cyc = 0; viol = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc > 2 && (host_ack || mem_we)) viol++;
      if (mem_rd && mem_we) viol++;
      if (cyc == 2) begin
        host_wr = 1'b1; host_addr = 6'd21; host_wdata = 36'hA_BCDE_F012;
      end
    end while (!done && cyc < 200);
    checks++;
    if (viol != 0 || cyc != 9 || error !== 1'b1) begin
      failures++; $display("FAIL arb_holdoff got viol=%0d cyc=%0d err=%b want 0 9 1", viol, cyc, error);
    end
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd21) begin
      failures++; $display("FAIL arb_ack_after_done got ack=%b we=%b addr=%0d want 1 1 21",
                           host_ack, mem_we, mem_addr);
    end
    @(negedge clk);
    host_wr = 1'b0;
    checks++;
    if (sram[21] !== 36'hA_BCDE_F012) begin
      failures++; $display("FAIL arb_late_write_data got %h want abcdef012", sram[21]);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, rds; logic [7:0] cls; logic er; logic saw_done;
    load_three();
    start = 1'b1; feat_in = 40'h00_00_10_40_00; cyc = 0; saw_done = 1'b0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) start = 1'b0;
      if (done) saw_done = 1'b1;
    end while (cyc < 4);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || class_out !== 8'h00) begin
      failures++; $display("FAIL reset_mid_state got busy=%b done=%b err=%b class=%h want 0 0 0 00",
                           busy, done, error, class_out);
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++; $display("FAIL reset_mid_no_done got done seen=%b want 0", saw_done);
    end
    run_walk(40'h00_00_10_40_00, cyc, cls, er, rds);
    checks++;
    if (cls !== 8'h2A || er !== 1'b0 || cyc != 7) begin
      failures++; $display("FAIL reset_mid_rewalk got class=%h err=%b cyc=%0d want 2a 0 7", cls, er, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single_node();
    test_bad_sel();
    test_three_level();
    test_loop();
    test_arbitration();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tree_walk_ctrl.md
# tree_walk_ctrl

Sequencer for the decision-tree inference datapath. It captures one feature vector of five 8-bit features, walks the node SRAM from the root node, and returns the leaf class. At each level it reads one node, compares the selected feature with the node threshold, and follows the left or right child pointer until it reaches a leaf. Outside a walk, it also passes host writes through to the same single-port SRAM, so the node table can be loaded.

## Interface
- ADDR_WIDTH, 6: node SRAM address width (64 nodes).
- NODE_WIDTH, 36: node word width; fixed at 36 by the node format below.
- NUM_FEAT, 5: number of features; valid feature select is 0..NUM_FEAT-1.
- ROOT_ADDR, 0: address of the root node.
- MAX_DEPTH, 16: maximum nodes visited per walk; range 1..255.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level request for a walk; requester holds it until busy=1.
- feat_in  in  40  features; feature i is in bits [8i+7:8i].
- busy  out  1  walk in progress.
- done  out  1  one-cycle pulse when a walk ends.
- class_out  out  8  leaf class; held until the next accepted start.
- error  out  1  walk aborted; valid with done and held with class_out.
- host_wr  in  1  host write request.
- host_addr  in  ADDR_WIDTH  host write address.
- host_wdata  in  NODE_WIDTH  host write data.
- host_ack  out  1  one-cycle pulse, the cycle the write is issued to the SRAM.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_rd  out  1  SRAM read enable; rdata is valid one cycle later.
- mem_we  out  1  SRAM write enable.
- mem_wdata  out  NODE_WIDTH  SRAM write data.
- mem_rdata  in  NODE_WIDTH  SRAM read data.

## Operation
- Node word layout:
  - [35:24] right pointer; [23:12] left pointer.
  - [11:9] feature select; [8] reserved, ignored.
  - [7:0] unsigned threshold.
- Pointer layout:
  - bit 11 = leaf flag.
  - Leaf: [7:0] is the class id.
  - Non-leaf: [ADDR_WIDTH-1:0] is the next node address; other bits are ignored.
- Decision: the selected feature is compared with the threshold as 8-bit unsigned values. If feature < threshold, take the left pointer; otherwise take the right pointer.
- feat_in is registered when start is accepted. Changes to feat_in during a walk have no effect.
- States:
  - IDLE: accept start when start=1 and host_wr=0; latch features; set node address to ROOT_ADDR and depth to 0; go to FETCH. When host_wr=1, drive mem_we, mem_addr=host_addr, mem_wdata=host_wdata combinationally and assert host_ack; host_wr wins over start in the same cycle.
  - FETCH: mem_rd=1, mem_addr=current node; depth increments; go to EVAL.
  - EVAL: decode mem_rdata and choose the child pointer.
    - Feature select >= NUM_FEAT: error, go to DONE.
    - Chosen pointer is a leaf: class_out = pointer[7:0], go to DONE.
    - depth == MAX_DEPTH: error, go to DONE.
    - Otherwise: node address = pointer address, go to FETCH.
  - DONE: done=1 for one cycle, busy drops, go to IDLE.
- On error, class_out=0 and error=1.
- Host writes are held off outside IDLE: host_ack stays low until IDLE. The host holds host_wr until it sees host_ack.
- start seen while busy is ignored.
- Only one SRAM operation is issued per cycle; mem_rd and mem_we are never both high.

## Timing
- Reset values: state IDLE; busy=0, done=0, error=0, class_out=0, host_ack=0, mem_rd=0, mem_we=0, mem_addr=0, mem_wdata=0.
- busy is high from the cycle after start is accepted until the end of the DONE cycle. The DONE cycle itself has busy=1 and done=1.
- Each tree level takes 2 cycles (FETCH, EVAL).
- A walk that visits k nodes asserts done exactly 2k+1 cycles after the edge that accepted start.
- class_out and error update on the edge that enters DONE.
- A new start is accepted at the earliest in the cycle after done.
- rst mid-walk: immediately back to IDLE with all outputs at reset values, and no done pulse. SRAM contents are unaffected.
- Node address wraps modulo 2^ADDR_WIDTH (pointer upper bits ignored); this is not an error.

## Test plan
- Single-node tree:
  - Setup: root 0 = threshold 0x80, feature select 0, left=0x803, right=0x805.
  - a1=0x7F -> class_out=3, done 3 cycles after accept.
  - a1=0x80 -> class_out=5; error=0 in both cases.
- Three-level walk:
  - Setup: root tests feature 2 against 0x10, right pointer goes to node 4; node 4 tests feature 4 against 0xF0, left pointer goes to node 9; node 9 right pointer = leaf class 0x2A.
  - Features a3=0x10, a5=0x00 and a value at/above node 9's threshold -> class_out=0x2A, done 7 cycles after accept.
  - mem_addr sequence 0, 4, 9.
- Loop with MAX_DEPTH=4:
  - Setup: node 0 left pointer = node 0.
  - Result: done after 9 cycles, error=1, class_out=0.
  - Exactly 4 mem_rd pulses.
- Bad feature select 7 at the root -> error=1, done 3 cycles after accept.
- Arbitration:
  - host_wr and start in the same IDLE cycle -> write issued with host_ack=1; start accepted the next cycle.
  - host_wr raised during a walk -> host_ack only after done; no mem_we while busy.
- Reset mid-walk:
  - rst asserted in the second EVAL -> the next cycle shows busy=0 and no done.
  - A new start then completes normally with the correct class.
